// File: rtl/multi_operand_accumulator.sv
// multi_operand_accumulator
//   Holds NUM_OPS unsigned operand slots loaded one at a time, then sums them
//   sequentially (one slot per cycle) and presents the registered total.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   din         operand data written on a load
//   ld          load request (level, acts on rising edge)
//   ld_idx      destination slot of a load; values >= NUM_OPS are ignored
//   clr         clear all slots (level, acts on rising edge)
//   start       begin a summation (level, acts on rising edge)
//   sum         result of the last completed summation
//   valid_mask  bit i set when slot i holds a loaded operand
//   busy        high while summing
//   done        one-cycle pulse when sum has just been updated

module multi_operand_accumulator #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NUM_OPS = 5,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned SUM_W   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               ld,
    input  logic [IDX_W-1:0]   ld_idx,
    input  logic               clr,
    input  logic               start,
    output logic [SUM_W-1:0]   sum,
    output logic [NUM_OPS-1:0] valid_mask,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e             state_q;
    logic               ld_q, clr_q, start_q;
    logic [WIDTH-1:0]   slot_q [NUM_OPS];
    logic [NUM_OPS-1:0] valid_q;
    logic [SUM_W-1:0]   acc_q;
    logic [SUM_W-1:0]   sum_q;
    logic [IDX_W-1:0]   ptr_q;

    logic               ld_edge, clr_edge, start_edge;
    logic [SUM_W-1:0]   addend;
    logic [SUM_W-1:0]   acc_next;
    logic               last_slot;

    assign ld_edge    = ld & ~ld_q;
    assign clr_edge   = clr & ~clr_q;
    assign start_edge = start & ~start_q;

    // Unloaded slots contribute zero even if their storage were stale.
    assign addend    = valid_q[ptr_q] ? SUM_W'(slot_q[ptr_q]) : '0;
    assign acc_next  = acc_q + addend;
    assign last_slot = (ptr_q == IDX_W'(NUM_OPS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ld_q    <= 1'b0;
            clr_q   <= 1'b0;
            start_q <= 1'b0;
            valid_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < int'(NUM_OPS); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            // Edge registers track inputs in every state so that a level held
            // through a summation does not fire once the FSM returns to idle.
            ld_q    <= ld;
            clr_q   <= clr;
            start_q <= start;

            unique case (state_q)
                StIdle: begin
                    // clr has priority over a coincident load.
                    if (clr_edge) begin
                        valid_q <= '0;
                        for (int i = 0; i < int'(NUM_OPS); i++) begin
                            slot_q[i] <= '0;
                        end
                    end else if (ld_edge) begin
                        for (int i = 0; i < int'(NUM_OPS); i++) begin
                            if (ld_idx == IDX_W'(i)) begin
                                slot_q[i]  <= din;
                                valid_q[i] <= 1'b1;
                            end
                        end
                    end
                    if (start_edge) begin
                        acc_q   <= '0;
                        ptr_q   <= '0;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    acc_q <= acc_next;
                    ptr_q <= ptr_q + 1'b1;
                    if (last_slot) begin
                        // Capture the final total on entry to StDone so sum is
                        // already valid in the cycle done is high.
                        sum_q   <= acc_next;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sum        = sum_q;
    assign valid_mask = valid_q;
    assign busy       = (state_q == StAccum);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Directed bench for multi_operand_accumulator: default parameter instance plus
// a wide instance (WIDTH=8, NUM_OPS=16, IDX_W=4, SUM_W=12).

module tb_multi_operand_accumulator;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       ld;
    logic [2:0] ld_idx;
    logic       clr;
    logic       start;
    logic [6:0] sum;
    logic [4:0] valid_mask;
    logic       busy;
    logic       done;

    logic [7:0]  w_din;
    logic        w_ld;
    logic [3:0]  w_ld_idx;
    logic        w_clr;
    logic        w_start;
    logic [11:0] w_sum;
    logic [15:0] w_valid_mask;
    logic        w_busy;
    logic        w_done;

    int assertions;
    int failures;

    multi_operand_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .ld         (ld),
        .ld_idx     (ld_idx),
        .clr        (clr),
        .start      (start),
        .sum        (sum),
        .valid_mask (valid_mask),
        .busy       (busy),
        .done       (done)
    );

    multi_operand_accumulator #(
        .WIDTH   (8),
        .NUM_OPS (16),
        .IDX_W   (4),
        .SUM_W   (12)
    ) dut_wide (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (w_din),
        .ld         (w_ld),
        .ld_idx     (w_ld_idx),
        .clr        (w_clr),
        .start      (w_start),
        .sum        (w_sum),
        .valid_mask (w_valid_mask),
        .busy       (w_busy),
        .done       (w_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] idx, input logic [3:0] val);
        ld_idx = idx;
        din    = val;
        ld     = 1'b1;
        tick();
        ld = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic wait_done(output bit seen);
        int n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            if (done) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        assertions++;
        if (sum !== 7'd0) begin
            failures++; $display("FAIL reset_sum: got %0d expected 0", sum);
        end
        assertions++;
        if (valid_mask !== 5'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 00000", valid_mask);
        end
        assertions++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        assertions++;
        if (w_sum !== 12'd0 || w_busy !== 1'b0) begin
            failures++; $display("FAIL reset_wide: got sum=%0d busy=%b expected 0 0", w_sum, w_busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_full();
        for (int i = 0; i < 5; i++) load(3'(i), 4'd15);
        assertions++;
        if (valid_mask !== 5'b11111) begin
            failures++; $display("FAIL full_valid: got %b expected 11111", valid_mask);
        end
        pulse_start();
        for (int k = 1; k <= 5; k++) begin
            assertions++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL full_busy_t%0d: got busy=%b done=%b expected 1 0", k, busy, done);
            end
            tick();
        end
        assertions++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL full_done: got done=%b busy=%b expected 1 0", done, busy);
        end
        assertions++;
        if (sum !== 7'd75) begin
            failures++; $display("FAIL full_sum: got %0d expected 75", sum);
        end
        tick();
        assertions++;
        if (done !== 1'b0 || sum !== 7'd75) begin
            failures++; $display("FAIL full_after: got done=%b sum=%0d expected 0 75", done, sum);
        end
    endtask

    task automatic test_sparse();
        bit seen;
        pulse_clr();
        assertions++;
        if (valid_mask !== 5'b0) begin
            failures++; $display("FAIL sparse_clr: got %b expected 00000", valid_mask);
        end
        load(3'd0, 4'd7);
        load(3'd3, 4'd9);
        assertions++;
        if (valid_mask !== 5'b01001) begin
            failures++; $display("FAIL sparse_valid: got %b expected 01001", valid_mask);
        end
        pulse_start();
        wait_done(seen);
        assertions++;
        if (!seen || sum !== 7'd16) begin
            failures++; $display("FAIL sparse_sum: got done=%b sum=%0d expected 1 16", seen, sum);
        end
        tick();
    endtask

    task automatic test_ignore();
        bit seen;
        pulse_start();
        load(3'd1, 4'd5);
        pulse_clr();
        wait_done(seen);
        assertions++;
        if (!seen || sum !== 7'd16) begin
            failures++; $display("FAIL ignore_busy_sum: got done=%b sum=%0d expected 1 16", seen, sum);
        end
        assertions++;
        if (valid_mask !== 5'b01001) begin
            failures++; $display("FAIL ignore_busy_valid: got %b expected 01001", valid_mask);
        end
        tick();
        load(3'd6, 4'd15);
        assertions++;
        if (valid_mask !== 5'b01001) begin
            failures++; $display("FAIL ignore_idx6_valid: got %b expected 01001", valid_mask);
        end
        pulse_start();
        wait_done(seen);
        assertions++;
        if (!seen || sum !== 7'd16) begin
            failures++; $display("FAIL ignore_rerun_sum: got done=%b sum=%0d expected 1 16", seen, sum);
        end
        tick();
    endtask

    task automatic test_clr_ld_same();
        bit seen;
        ld_idx = 3'd2;
        din    = 4'd4;
        ld     = 1'b1;
        clr    = 1'b1;
        tick();
        ld  = 1'b0;
        clr = 1'b0;
        tick();
        assertions++;
        if (valid_mask !== 5'b0) begin
            failures++; $display("FAIL clrld_valid: got %b expected 00000", valid_mask);
        end
        assertions++;
        if (sum !== 7'd16) begin
            failures++; $display("FAIL clrld_sum_hold: got %0d expected 16", sum);
        end
        pulse_start();
        wait_done(seen);
        assertions++;
        if (!seen || sum !== 7'd0) begin
            failures++; $display("FAIL clrld_sum: got done=%b sum=%0d expected 1 0", seen, sum);
        end
        tick();
        // start, clr and ld together: clear wins over the load and the sum is 0.
        load(3'd1, 4'd3);
        ld_idx = 3'd2;
        din    = 4'd4;
        ld     = 1'b1;
        clr    = 1'b1;
        start  = 1'b1;
        tick();
        ld    = 1'b0;
        clr   = 1'b0;
        start = 1'b0;
        assertions++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL triple_busy: got %b expected 1", busy);
        end
        wait_done(seen);
        assertions++;
        if (!seen || sum !== 7'd0 || valid_mask !== 5'b0) begin
            failures++;
            $display("FAIL triple_sum: got done=%b sum=%0d valid=%b expected 1 0 00000",
                     seen, sum, valid_mask);
        end
        tick();
    endtask

    task automatic test_held_start();
        bit seen;
        load(3'd4, 4'd10);
        start = 1'b1;
        tick();
        wait_done(seen);
        assertions++;
        if (!seen || sum !== 7'd10) begin
            failures++; $display("FAIL held_sum: got done=%b sum=%0d expected 1 10", seen, sum);
        end
        tick();
        tick();
        assertions++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL held_retrigger: got busy=%b done=%b expected 0 0", busy, done);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        int dones;
        load(3'd0, 4'd15);
        pulse_start();
        tick();
        tick();
        // Third ACCUM cycle.
        rst_n = 1'b0;
        tick();
        assertions++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        assertions++;
        if (sum !== 7'd0 || valid_mask !== 5'b0) begin
            failures++; $display("FAIL abort_state: got sum=%0d valid=%b expected 0 00000", sum, valid_mask);
        end
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dones++;
        end
        assertions++;
        if (dones !== 0) begin
            failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones);
        end
    endtask

    task automatic test_reset_release_edge();
        bit seen;
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        assertions++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL release_edge_busy: got %b expected 1", busy);
        end
        start = 1'b0;
        wait_done(seen);
        assertions++;
        if (!seen || sum !== 7'd0) begin
            failures++; $display("FAIL release_edge_sum: got done=%b sum=%0d expected 1 0", seen, sum);
        end
        tick();
    endtask

    task automatic test_wide();
        for (int i = 0; i < 16; i++) begin
            w_ld_idx = 4'(i);
            w_din    = 8'd255;
            w_ld     = 1'b1;
            tick();
            w_ld = 1'b0;
            tick();
        end
        assertions++;
        if (w_valid_mask !== 16'hffff) begin
            failures++; $display("FAIL wide_valid: got %h expected ffff", w_valid_mask);
        end
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            assertions++;
            if (w_busy !== 1'b1 || w_done !== 1'b0) begin
                failures++;
                $display("FAIL wide_busy_t%0d: got busy=%b done=%b expected 1 0", k, w_busy, w_done);
            end
            tick();
        end
        assertions++;
        if (w_done !== 1'b1 || w_sum !== 12'd4080) begin
            failures++; $display("FAIL wide_done_t17: got done=%b sum=%0d expected 1 4080", w_done, w_sum);
        end
        tick();
        assertions++;
        if (w_done !== 1'b0) begin
            failures++; $display("FAIL wide_done_pulse: got %b expected 0", w_done);
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        rst_n      = 1'b0;
        din        = '0;
        ld         = 1'b0;
        ld_idx     = '0;
        clr        = 1'b0;
        start      = 1'b0;
        w_din      = '0;
        w_ld       = 1'b0;
        w_ld_idx   = '0;
        w_clr      = 1'b0;
        w_start    = 1'b0;
        #2;
        test_reset();
        test_all_full();
        test_sparse();
        test_ignore();
        test_clr_ld_same();
        test_held_start();
        test_reset_abort();
        test_reset_release_edge();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/multi_operand_accumulator.md
MULTI_OPERAND_ACCUMULATOR -- requirements
Module: multi_operand_accumulator

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits.
REQ-002 Parameter NUM_OPS, default 5: number of operand slots; legal range 2..16.
REQ-003 Parameter IDX_W, default 3: slot index width; SHALL satisfy 2^IDX_W >= NUM_OPS.
REQ-004 Parameter SUM_W, default 7: result width; SHALL satisfy SUM_W >= WIDTH + ceil(log2(NUM_OPS)), so the sum never overflows.
REQ-005 clk  input  1: single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1: reset, synchronous and active-low.
REQ-007 din  input  WIDTH: operand data, unsigned.
REQ-008 ld  input  1: load request, level input (debounced button); acts on its rising edge only.
REQ-009 ld_idx  input  IDX_W: destination slot for a load.
REQ-010 clr  input  1: clear all slots, level; acts on its rising edge only.
REQ-011 start  input  1: start summation, level; acts on its rising edge only.
REQ-012 sum  output  SUM_W: registered result of the last completed summation.
REQ-013 valid_mask  output  NUM_OPS: bit i high when slot i holds a loaded operand.
REQ-014 busy  output  1: high while the FSM is in ACCUM.
REQ-015 done  output  1: single-cycle pulse marking a completed summation.

Function
REQ-016 Edge detection: ld, clr and start SHALL each be registered once. An edge SHALL be the cycle where the input is 1 and its registered copy is 0. No other synchronisation is required.
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-018 IDLE: ld edge with ld_idx < NUM_OPS SHALL write din into slot ld_idx and set valid_mask[ld_idx] on the same clock edge. ld_idx >= NUM_OPS SHALL be ignored.
REQ-019 Reloading an already-valid slot SHALL overwrite it; the last write wins.
REQ-020 IDLE: clr edge SHALL zero all slots and valid_mask. If a clr edge and an ld edge occur in the same cycle, clr SHALL win and the load SHALL be discarded.
REQ-021 IDLE: start edge SHALL zero the internal accumulator, reset the slot pointer to 0 and enter ACCUM.
REQ-022 If start, ld and clr edges coincide in IDLE, clr and start SHALL both take effect, ld SHALL be discarded, and the summation SHALL yield 0.
REQ-023 ACCUM: each cycle SHALL add slot[pointer], zero-extended to SUM_W, into the accumulator, then increment the pointer. Slots with valid_mask = 0 SHALL contribute 0.
REQ-024 ACCUM SHALL last exactly NUM_OPS cycles. After the add of slot NUM_OPS-1 the FSM SHALL enter DONE.
REQ-025 DONE: sum SHALL be loaded from the accumulator, done SHALL be 1 for this single cycle, and the next state SHALL be IDLE.
REQ-026 Latency: for a start edge detected in cycle t, busy SHALL be high in cycles t+1..t+NUM_OPS, done SHALL be high in cycle t+NUM_OPS+1, and sum SHALL be valid from cycle t+NUM_OPS+1.
REQ-027 sum SHALL hold its value until the next DONE, independent of later loads or clears.
REQ-028 In ACCUM and DONE, ld, clr and start edges SHALL be ignored and not queued. The edge-detect registers SHALL still track their inputs, so a level held across DONE does not re-trigger.
REQ-029 busy and done SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-030 The accumulator SHALL be SUM_W wide. No carry-out port exists: by REQ-004, a carry beyond SUM_W is impossible.

Reset
REQ-031 rst_n = 0 sampled at a clock edge SHALL set: state IDLE; sum, valid_mask, slots, accumulator and pointer to 0; busy and done to 0; edge-detect registers to 0.
REQ-032 Reset asserted in ACCUM or DONE SHALL abort the operation. No done pulse SHALL follow, and sum SHALL read 0.
REQ-033 An input held high through reset release SHALL produce an edge in the first cycle after release.

Verification
REQ-034 Defaults: load 15 into slots 0..4, then start -> busy high for 5 cycles, one-cycle done, sum = 75.
REQ-035 Load slots 0 and 3 only, with 7 and 9 -> valid_mask = 5'b01001, sum = 16.
REQ-036 Loads and clr during busy, and ld_idx = 6 while idle -> slot contents and valid_mask unchanged, sum unchanged from the prior run.
REQ-037 clr and ld edges in the same idle cycle -> valid_mask = 0, and a subsequent start gives sum = 0.
REQ-038 rst_n low on the 3rd ACCUM cycle -> no done pulse, sum = 0, valid_mask = 0, busy = 0 on the next cycle.
REQ-039 Parameter set WIDTH = 8, NUM_OPS = 16, IDX_W = 4, SUM_W = 12 with all slots at 255 -> sum = 4080, done at cycle t+17.
